// File: rtl/rsc_inter.sv
// Turbo-style front end: systematic copy, interleaved copy and two RSC (13,15) parity words.
// Define RSC_STATE_CARRY_EN to carry encoder state across words instead of restarting at 000.
module rsc_inter (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out,
    output logic [7:0] out3
);

    logic [7:0] int_word;
    logic [2:0] st_a_in, st_b_in;
    logic [2:0] st_a_end, st_b_end;
    logic [7:0] par_a, par_b;

    // Result packs {end_state, parity}; state is {s3, s2, s1}.
    function automatic logic [10:0] rsc_word(input logic [7:0] u, input logic [2:0] st);
        logic       s1, s2, s3, a;
        logic [7:0] p;
        s1 = st[0];
        s2 = st[1];
        s3 = st[2];
        p  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            a    = u[k] ^ s2 ^ s3;
            p[k] = a ^ s1 ^ s3;
            s3   = s2;
            s2   = s1;
            s1   = a;
        end
        return {s3, s2, s1, p};
    endfunction

    // P(i) = (5*i + 3) mod 8
    always_comb begin
        int_word = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int_word[i] = in[(5 * i + 3) % 8];
        end
    end

`ifdef RSC_STATE_CARRY_EN
    logic [2:0] st_a_q, st_b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_a_q <= 3'b000;
            st_b_q <= 3'b000;
        end else begin
            st_a_q <= st_a_end;
            st_b_q <= st_b_end;
        end
    end

    assign st_a_in = st_a_q;
    assign st_b_in = st_b_q;
`else
    assign st_a_in = 3'b000;
    assign st_b_in = 3'b000;
`endif

    always_comb begin
        {st_a_end, par_a} = rsc_word(in, st_a_in);
        {st_b_end, par_b} = rsc_word(int_word, st_b_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out1 <= 8'h00;
            out2 <= 8'h00;
            out  <= 8'h00;
            out3 <= 8'h00;
        end else begin
            out1 <= in;
            out2 <= par_a;
            out  <= int_word;
            out3 <= par_b;
        end
    end

endmodule

// File: tb/tb_rsc_inter.sv
// Scoreboard bench for rsc_inter: stimulus pushes model results, a monitor pops and compares.
module tb_rsc_inter;

    logic       clk;
    logic       reset;
    logic [7:0] in;
    logic [7:0] out1, out2, out, out3;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] o1;
        logic [7:0] o2;
        logic [7:0] oi;
        logic [7:0] o3;
    } exp_t;

    exp_t exp_q[$];

    // Model encoder state, bits held as integers s1,s2,s3.
    int ma_s1, ma_s2, ma_s3, mb_s1, mb_s2, mb_s3;

    rsc_inter dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .out1 (out1),
        .out2 (out2),
        .out  (out),
        .out3 (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, got, want);
        end
    endtask

    function automatic logic [7:0] interleave(input logic [7:0] w);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = w[(5 * i + 3) % 8];
        return r;
    endfunction

    // Parity word from recursion a = u+s2+s3, p = a+s1+s3 over GF(2), bit 0 first.
    task automatic model_enc(input logic [7:0] u, inout int s1, inout int s2, inout int s3,
                             output logic [7:0] p);
        int a;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            a = (int'(u[k]) + s2 + s3) % 2;
            if ((a + s1 + s3) % 2 == 1) p = p | (8'h01 << k);
            s3 = s2;
            s2 = s1;
            s1 = a;
        end
`ifndef RSC_STATE_CARRY_EN
        s1 = 0;
        s2 = 0;
        s3 = 0;
`endif
    endtask

    task automatic model_reset();
        ma_s1 = 0; ma_s2 = 0; ma_s3 = 0;
        mb_s1 = 0; mb_s2 = 0; mb_s3 = 0;
    endtask

    // Call at negedge: drives the word and queues its expected registered response.
    task automatic drive(input logic [7:0] w);
        exp_t e;
        logic [7:0] iw;
        iw   = interleave(w);
        e.o1 = w;
        e.oi = iw;
        model_enc(w, ma_s1, ma_s2, ma_s3, e.o2);
        model_enc(iw, mb_s1, mb_s2, mb_s3, e.o3);
        in = w;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out1"}, out1, 8'h00);
        check({tag, ".out2"}, out2, 8'h00);
        check({tag, ".out"},  out,  8'h00);
        check({tag, ".out3"}, out3, 8'h00);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb.out1", out1, e.o1);
            check("sb.out2", out2, e.o2);
            check("sb.out",  out,  e.oi);
            check("sb.out3", out3, e.o3);
        end
    end

    initial begin
        model_reset();
        reset = 1'b1;
        in    = 8'hA5;
        #2;
        check_zero("rst_async");
        repeat (3) @(negedge clk);
        check_zero("rst_held");
        reset = 1'b0;
        // First post-reset word; REQ-style constant check after the edge.
        drive(8'hA5);
        check("post_rst.out1", out1, 8'hA5);

        // Impulse then zero: shows per-word restart or carried state.
        drive(8'h01);
        check("imp.out2", out2, 8'h4F);
        check("imp.out",  out,  8'h02);
        drive(8'h00);
`ifdef RSC_STATE_CARRY_EN
        check("carry.out2", out2, 8'hA7);
`else
        check("zero.out2", out2, 8'h00);
        check("zero.out3", out3, 8'h00);
        drive(8'h01);
        check("imp.out3", out3, 8'h9E);
        drive(8'hFF);
        check("ff.out2", out2, 8'hC5);
        check("ff.out3", out3, 8'hC5);
        drive(8'h03);
        check("lin.out2", out2, 8'hD1);
`endif

        for (int n = 0; n < 200; n++) drive(8'($urandom_range(0, 255)));

        // Mid-cycle asynchronous reset with nonzero outputs.
        drive(8'hFF);
        @(posedge clk);
        #3;
        check("pre_rst.out1", out1, 8'hFF);
        reset = 1'b1;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(8'h01);
        check("restart.out2", out2, 8'h4F);
        for (int n = 0; n < 50; n++) drive(8'($urandom_range(0, 255)));
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb.drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit 100000");
        $fatal(1);
    end

endmodule
